// File: rtl/secuenciador_bebida.sv
// Drink-dispensing sequencer: walks the ingredient states 8..13, holding each
// one for the time reported by the ingredient-time block, and drives the valves.
module secuenciador_bebida #(
  parameter int TICKS_POR_SEGUNDO = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic       cancelar,
  input  logic [1:0] bebida,
  input  logic [1:0] segundos,
  output logic [1:0] bebida_sel,
  output logic [3:0] estadoActual,
  output logic [4:0] valvulas,
  output logic       ocupado,
  output logic       lista
);

  localparam int PW = $clog2(TICKS_POR_SEGUNDO);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_POR_SEGUNDO - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    AGUA      = 4'd8,
    CAFE      = 4'd9,
    LECHE     = 4'd10,
    CHOCOLATE = 4'd11,
    AZUCAR    = 4'd12,
    LISTA     = 4'd13
  } estado_t;

  estado_t       state_reg, state_next;
  logic [1:0]    bebida_sel_reg, bebida_sel_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    seg_reg, seg_next;
  logic          fin;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      bebida_sel_reg <= 2'd0;
      presc_reg      <= '0;
      seg_reg        <= 2'd0;
    end else begin
      state_reg      <= state_next;
      bebida_sel_reg <= bebida_sel_next;
      presc_reg      <= presc_next;
      seg_reg        <= seg_next;
    end
  end

  // Zero-second states last a single cycle; otherwise leave on the last tick of the last second.
  assign fin = (segundos == 2'd0) ||
               ((presc_reg == PRESC_MAX) && (seg_reg == segundos - 2'd1));

  always_comb begin
    state_next      = state_reg;
    bebida_sel_next = bebida_sel_reg;
    case (state_reg)
      IDLE: begin
        if (inicio && !cancelar) begin
          state_next      = AGUA;
          bebida_sel_next = bebida;
        end
      end
      AGUA:      if (cancelar) state_next = IDLE; else if (fin) state_next = CAFE;
      CAFE:      if (cancelar) state_next = IDLE; else if (fin) state_next = LECHE;
      LECHE:     if (cancelar) state_next = IDLE; else if (fin) state_next = CHOCOLATE;
      CHOCOLATE: if (cancelar) state_next = IDLE; else if (fin) state_next = AZUCAR;
      AZUCAR:    if (cancelar) state_next = IDLE; else if (fin) state_next = LISTA;
      LISTA:     if (cancelar || fin) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Counters restart on every state change so each dwell is measured from its first cycle.
  always_comb begin
    presc_next = presc_reg;
    seg_next   = seg_reg;
    if ((state_next != state_reg) || (state_reg == IDLE)) begin
      presc_next = '0;
      seg_next   = 2'd0;
    end else if (presc_reg == PRESC_MAX) begin
      presc_next = '0;
      seg_next   = seg_reg + 2'd1;
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  always_comb begin
    valvulas = 5'b00000;
    if (segundos != 2'd0) begin
      case (state_reg)
        AGUA:      valvulas = 5'b00001;
        CAFE:      valvulas = 5'b00010;
        LECHE:     valvulas = 5'b00100;
        CHOCOLATE: valvulas = 5'b01000;
        AZUCAR:    valvulas = 5'b10000;
        default:   valvulas = 5'b00000;
      endcase
    end
  end

  assign bebida_sel   = bebida_sel_reg;
  assign estadoActual = state_reg;
  assign ocupado      = (state_reg != IDLE);
  assign lista        = (state_reg == LISTA);

endmodule

// File: tb/tb_secuenciador_bebida.sv
// Bench for secuenciador_bebida: dwell-countdown reference model checked every
// cycle, plus literal cycle-by-cycle pins taken from hand-computed timelines.
module tb_secuenciador_bebida;

  localparam int TICKS = 4;

  logic       clk = 1'b0;
  logic       rst, inicio, cancelar;
  logic [1:0] bebida, segundos, bebida_sel;
  logic [3:0] estadoActual;
  logic [4:0] valvulas;
  logic       ocupado, lista;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Ingredient seconds per drink, states 8..13
  int tab [4][6] = '{'{2, 3, 0, 0, 1, 2},
                     '{1, 2, 2, 0, 1, 2},
                     '{1, 1, 2, 0, 1, 2},
                     '{1, 1, 1, 2, 1, 2}};

  function automatic int tsec(input int s, input int b);
    if (s >= 8 && s <= 13) return tab[b][s-8];
    return 0;
  endfunction

  assign segundos = 2'(tsec(int'(estadoActual), int'(bebida_sel)));

  secuenciador_bebida #(.TICKS_POR_SEGUNDO(TICKS)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .cancelar(cancelar), .bebida(bebida),
    .segundos(segundos), .bebida_sel(bebida_sel), .estadoActual(estadoActual),
    .valvulas(valvulas), .ocupado(ocupado), .lista(lista)
  );

  always #5 clk = ~clk;

  // Reference model: state code, latched drink and cycles left in the current state.
  int m_state = 0, m_bsel = 0, m_left = 0;

  function automatic void m_enter(input int s);
    int t;
    m_state = s;
    t = tsec(s, m_bsel);
    m_left = (t == 0) ? 1 : t * TICKS;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_state = 0;
      m_bsel  = 0;
    end else if (m_state == 0) begin
      if (inicio && !cancelar) begin
        m_bsel = int'(bebida);
        m_enter(8);
      end
    end else if (cancelar) begin
      m_state = 0;
    end else begin
      m_left--;
      if (m_left == 0) m_enter((m_state == 13) ? 0 : m_state + 1);
    end
  end

  task automatic pin(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int ev;
      int t;
      t  = tsec(m_state, m_bsel);
      ev = (m_state >= 8 && m_state <= 12 && t != 0) ? (1 << (m_state - 8)) : 0;
      pin("model_estado", int'(estadoActual), m_state);
      pin("model_bebida_sel", int'(bebida_sel), m_bsel);
      pin("model_valvulas", int'(valvulas), ev);
      pin("model_lista", int'(lista), int'(m_state == 13));
      pin("model_ocupado", int'(ocupado), int'(m_state != 0));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse inicio for one edge; afterwards the outputs show cycle 1 of the run.
  task automatic arrancar(input logic [1:0] b);
    bebida = b;
    inicio = 1'b1;
    tick(1);
    inicio = 1'b0;
    $display("start bebida=%0d estado=%0d", b, estadoActual);
  endtask

  initial begin
    rst = 1'b0; inicio = 1'b0; cancelar = 1'b0; bebida = 2'd0;
    tick(2);
    chk_en = 1'b1;
    rst = 1'b1;
    pin("reset_estado", int'(estadoActual), 0);
    pin("reset_valvulas", int'(valvulas), 0);
    pin("reset_ocupado", int'(ocupado), 0);
    tick(2);

    // Espresso timeline
    arrancar(2'd0);
    pin("esp_c1_estado", int'(estadoActual), 8);
    pin("esp_c1_valv", int'(valvulas), 1);
    tick(7);  pin("esp_c8_estado", int'(estadoActual), 8);
    tick(1);  pin("esp_c9_estado", int'(estadoActual), 9);
    pin("esp_c9_valv", int'(valvulas), 2);
    tick(12); pin("esp_c21_estado", int'(estadoActual), 10);
    pin("esp_c21_valv", int'(valvulas), 0);
    tick(1);  pin("esp_c22_estado", int'(estadoActual), 11);
    tick(1);  pin("esp_c23_estado", int'(estadoActual), 12);
    pin("esp_c23_valv", int'(valvulas), 16);
    tick(4);  pin("esp_c27_estado", int'(estadoActual), 13);
    pin("esp_c27_lista", int'(lista), 1);
    tick(8);  pin("esp_c35_estado", int'(estadoActual), 0);
    pin("esp_c35_ocupado", int'(ocupado), 0);
    tick(2);

    // Mocaccino
    arrancar(2'd3);
    tick(12); pin("moc_c13_estado", int'(estadoActual), 11);
    pin("moc_c13_valv", int'(valvulas), 8);
    tick(19); pin("moc_c32_estado", int'(estadoActual), 13);
    tick(1);  pin("moc_c33_estado", int'(estadoActual), 0);
    tick(2);

    // Capuccino
    arrancar(2'd2);
    tick(8);  pin("cap_c9_estado", int'(estadoActual), 10);
    pin("cap_c9_valv", int'(valvulas), 4);
    tick(7);  pin("cap_c16_estado", int'(estadoActual), 10);
    tick(1);  pin("cap_c17_estado", int'(estadoActual), 11);
    pin("cap_c17_valv", int'(valvulas), 0);
    tick(13); pin("cap_c30_estado", int'(estadoActual), 0);
    tick(2);

    // Cancel during CAFE, then restart with cafe con leche
    arrancar(2'd0);
    tick(9); pin("can_c10_estado", int'(estadoActual), 9);
    cancelar = 1'b1; tick(1); cancelar = 1'b0;
    pin("can_c11_estado", int'(estadoActual), 0);
    pin("can_c11_valv", int'(valvulas), 0);
    pin("can_c11_ocupado", int'(ocupado), 0);
    tick(1);
    arrancar(2'd1);
    pin("ccl_c1_bsel", int'(bebida_sel), 1);
    tick(3); pin("ccl_c4_estado", int'(estadoActual), 8);
    tick(1); pin("ccl_c5_estado", int'(estadoActual), 9);
    cancelar = 1'b1; tick(1); cancelar = 1'b0;
    pin("ccl_cancel_estado", int'(estadoActual), 0);
    pin("ccl_cancel_bsel", int'(bebida_sel), 1);
    tick(1);

    // inicio together with cancelar in IDLE
    bebida = 2'd2; inicio = 1'b1; cancelar = 1'b1; tick(1);
    inicio = 1'b0; cancelar = 1'b0;
    pin("both_idle_estado", int'(estadoActual), 0);
    tick(1);

    // Input isolation: bebida/inicio changed mid-run and inicio in the last LISTA cycle
    arrancar(2'd0);
    tick(4); bebida = 2'd3; inicio = 1'b1; tick(1); inicio = 1'b0;
    pin("iso_c6_bsel", int'(bebida_sel), 0);
    tick(3); pin("iso_c9_estado", int'(estadoActual), 9);
    tick(25); pin("iso_c34_estado", int'(estadoActual), 13);
    inicio = 1'b1; tick(1); inicio = 1'b0;
    pin("iso_c35_estado", int'(estadoActual), 0);
    tick(1); pin("iso_c36_estado", int'(estadoActual), 0);
    tick(1);

    // Reset mid-run (state 11), then reset with inicio in IDLE
    arrancar(2'd3);
    tick(12); pin("rst_c13_estado", int'(estadoActual), 11);
    rst = 1'b0; tick(1); rst = 1'b1;
    pin("rst_run_estado", int'(estadoActual), 0);
    pin("rst_run_bsel", int'(bebida_sel), 0);
    pin("rst_run_valv", int'(valvulas), 0);
    pin("rst_run_lista", int'(lista), 0);
    pin("rst_run_ocupado", int'(ocupado), 0);
    tick(1);
    bebida = 2'd1; rst = 1'b0; inicio = 1'b1; tick(1);
    rst = 1'b1; inicio = 1'b0;
    pin("rst_inicio_estado", int'(estadoActual), 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secuenciador_bebida.md
Name: secuenciador_bebida

Overview:
- Sequencing FSM for the drink-dispensing phase of the coffee machine.
- On a start request it latches the selected drink and drives `estadoActual` through the ingredient states 8..13.
- The ingredient-time block turns `estadoActual` and `bebida_sel` into `segundos`. This block consumes `segundos` to time each state, holding the matching valve on for that many seconds.
- Sits between the selection/payment logic (upstream) and the valve drivers and display (downstream).

Parameters:
- TICKS_POR_SEGUNDO, 50_000_000, clock cycles per second. Must be >= 2; sims use 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- inicio  input  1  start request, sampled only in IDLE
- cancelar  input  1  synchronous abort, any state
- bebida  input  2  drink code: 0 espresso, 1 cafe con leche, 2 capuccino, 3 mocaccino
- segundos  input  2  dispense time for the current `estadoActual`/`bebida_sel`, from the ingredient-time block
- bebida_sel  output  2  registered drink code, feeds the ingredient-time block
- estadoActual  output  4  current state code
- valvulas  output  5  one-hot valve enables: [0] agua, [1] cafe, [2] leche, [3] chocolate, [4] azucar
- ocupado  output  1  high whenever estadoActual != 0
- lista  output  1  drink-ready indicator

Behaviour:
- Reset (rst==0 at a clk edge) forces the following values next cycle:
  - estadoActual=0, bebida_sel=0, valvulas=0, ocupado=0, lista=0.
  - Prescaler and second counter cleared.
  - Reset overrides all other inputs.
- State codes: 0 IDLE, 8 AGUA, 9 CAFE, 10 LECHE, 11 CHOCOLATE, 12 AZUCAR, 13 LISTA.
  - Codes 1..7 and 14..15 are never produced.
  - If reached by fault, they return to IDLE next cycle.
- IDLE:
  - If inicio==1: bebida_sel<=bebida and estadoActual<=8 next cycle.
  - Otherwise remain in IDLE.
  - bebida is ignored outside IDLE; bebida_sel is constant for the whole run.
- Timing counters:
  - `presc` counts 0..TICKS_POR_SEGUNDO-1, width $clog2(TICKS_POR_SEGUNDO).
  - `seg_cnt` is 2 bits.
  - Both are zeroed on every state change.
  - When presc==TICKS-1: presc wraps to 0 and seg_cnt increments.
- Dwell in timed states (8..13):
  - If segundos==0: dwell exactly 1 cycle, then advance.
  - Else: advance on the cycle where presc==TICKS-1 and seg_cnt==segundos-1, giving a dwell of exactly segundos*TICKS cycles.
  - `segundos` is combinational from registered signals, so it is valid in the first cycle of each state.
- Transitions: 8→9→10→11→12→13→0.
- valvulas:
  - Registered-equivalent; exactly one bit is high while in states 8..12 and segundos!=0.
  - The bit corresponds to the state: 8→[0], 9→[1], 10→[2], 11→[3], 12→[4].
  - All zero otherwise, including zero-second states.
- lista: high for all cycles in state 13.
- ocupado: high in all states except IDLE.
- cancelar==1 in any non-IDLE state:
  - Next cycle estadoActual=0, valvulas=0, lista=0, counters cleared.
  - bebida_sel is retained.
- Simultaneous events:
  - inicio and cancelar both high in IDLE: cancelar wins, remain IDLE.
  - inicio high during a run: ignored.
  - inicio high in the last cycle of LISTA: ignored; a new start needs inicio in IDLE.

Test Plan (TICKS_POR_SEGUNDO=4):
- Espresso: bebida=0, inicio pulse at cycle 0 → from cycle 1, estadoActual dwell sequence:
  - 8 for 8 cycles (valvulas=00001), 9 for 12 (00010)
  - 10 for 1 and 11 for 1 (valvulas=0)
  - 12 for 4 (10000), 13 for 8 (lista=1)
  - IDLE at cycle 35, ocupado=0.
- Mocaccino: bebida=3 → dwells 8:4, 9:4, 10:4, 11:8 (valvulas=01000), 12:4, 13:8; IDLE at cycle 33.
- Capuccino: bebida=2 → leche dwell 8 cycles with valvulas=00100; chocolate dwell 1 cycle with valvulas=0.
- Cancel: espresso started, cancelar=1 at cycle 10 (state 9) → cycle 11 estadoActual=0, valvulas=0, ocupado=0. A new inicio with bebida=1 restarts at state 8 with full dwell.
- Input isolation: bebida changed 0→3 and inicio re-pulsed mid-run → bebida_sel stays 0, timing unchanged. inicio+cancelar together in IDLE → stays IDLE.
- Reset: rst=0 for one cycle during state 11 → next cycle all outputs zero, estadoActual=0; rst=0 with inicio=1 in IDLE → no start.
